up_counter_ctrl: RTL and testbench
==================================

// Module: up_counter_ctrl
// PURPOSE
//   Sequencer for the free-running 4-bit up counter datapath.
//   Adds start/stop/pause control, a programmable terminal count, a clock prescaler,
//   and one-shot or auto-reload modes.
//   Owns the count register and reports busy/done status to the surrounding control logic.
// PARAMETERS
//   WIDTH       4   count and limit width in bits
//   PRESCALE_W  4   prescale field width; count advances once per (prescale+1) clocks
// PORTS
//   clk       in   1           single clock, rising-edge active
//   rst       in   1           asynchronous reset, active-high
//   start     in   1           begin a run; sampled only in IDLE
//   stop      in   1           abort; returns to IDLE from any state
//   pause     in   1           level; freezes the count while high in RUN
//   mode      in   1           0 = one-shot, 1 = auto-reload; latched at start
//   limit     in   WIDTH       terminal count; latched at start
//   prescale  in   PRESCALE_W  tick divider; latched at start
//   count     out  WIDTH       current count value (registered)
//   busy      out  1           high in RUN and HOLD
//   done      out  1           1-cycle pulse on each terminal event (registered)
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, count=0, busy=0, done=0.
//   Prescaler and the latched limit/prescale/mode are all cleared.
//   Outputs change immediately on rst rising, with no clock edge needed.
// - FSM states:
//   IDLE (busy=0): start=1 & stop=0 -> latch limit/prescale/mode, count<=0, prescaler<=0, go to RUN.
//   RUN (busy=1): pause=1 -> HOLD. Otherwise the prescaler increments each clock.
//     tick = (prescaler == latched prescale); on tick the prescaler is cleared.
//   HOLD (busy=1): count and prescaler frozen; pause=0 -> RUN.
//     The prescaler phase is preserved across the pause.
//   DONE (busy=0): one cycle only, then IDLE. count holds its final value.
// - Tick in RUN:
//   count != limit -> count <= count+1.
//   count == limit -> terminal event: done<=1 for one cycle, then:
//     one-shot: count holds at limit and state goes to DONE.
//       busy drops on the same edge that raises done.
//     auto-reload: count <= 0 and state stays RUN.
// - Priority per cycle: stop > pause > tick.
//   stop in RUN/HOLD/DONE -> IDLE, count<=0, prescaler<=0, done<=0.
//   start together with stop in IDLE -> remain in IDLE.
//   start while busy is ignored; latched parameters do not change mid-run.
//   Changes on the limit/prescale/mode inputs during a run have no effect.
// - Timing: start sampled at edge N -> RUN with count=0 after edge N.
//   First increment occurs at edge N+(prescale+1).
//   One period = (limit+1)*(prescale+1) clocks.
// - Boundaries:
//   limit=0 gives a terminal event on every tick.
//   limit=2^WIDTH-1 counts to all-ones, then reloads to 0 (no silent natural wrap).
//   The count arithmetic never exceeds WIDTH bits.
// - rst asserted mid-run aborts immediately.
//   After rst deasserts, the block waits in IDLE for a new start.
// TESTING
// 1. Reset: assert rst at count=3 in RUN, between edges.
//    -> count=0, busy=0, done=0 before the next clk edge.
//    -> no activity until start.
// 2. One-shot, limit=5, prescale=0, start at edge N.
//    -> count 1..5 at edges N+1..N+5.
//    -> done=1 only after edge N+6, with busy=0 and count=5.
//    -> IDLE one cycle later.
// 3. Auto-reload, limit=3, prescale=0.
//    -> count 0,1,2,3,0,1,...; done pulses every 4 clocks; busy stays 1.
//    -> with limit=15: count goes 15->0 with a done pulse.
// 4. Prescale=2, limit=2, one-shot.
//    -> count advances every 3 clocks.
//    -> done after 9 clocks from start, count=2.
// 5. Pause held 4 cycles at count=2 with prescaler mid-phase.
//    -> count stays 2 and busy stays 1.
//    -> on release, the remaining prescale phase completes before the increment.
// 6. Stop at count=4 -> IDLE, count=0, no done.
//    -> start+stop in the same cycle leaves IDLE.
//    -> start during RUN with a new limit does not change the run.

Source files
------------

// File: rtl/up_counter_ctrl.sv
// up_counter_ctrl
//   Run-control sequencer around a WIDTH-bit up counter. A run is started from
//   IDLE. It counts 0..limit, advancing once every (prescale+1) clocks. On
//   reaching the terminal count it pulses done. In one-shot mode it then stops.
//   In auto-reload mode it wraps back to 0 and keeps running. Runs can be
//   paused (the prescaler phase is kept) or aborted with stop.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active high
//   start     begin a run (only looked at in IDLE)
//   stop      abort to IDLE from any state, clears count
//   pause     level; freezes count and prescaler while high
//   mode      0 = one-shot, 1 = auto-reload (latched at start)
//   limit     terminal count (latched at start)
//   prescale  tick divider, count advances every prescale+1 clocks (latched)
//   count     current count value (registered)
//   busy      high in RUN and HOLD
//   done      one-cycle pulse per terminal event (registered)
module up_counter_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state, state_nx;

  // Run parameters captured at start; inputs are ignored for the rest of a run.
  logic [WIDTH-1:0]      lim_q, lim_nx;
  logic [PRESCALE_W-1:0] psc_q, psc_nx;
  logic                  auto_q, auto_nx;

  // Prescaler phase: counts 0..psc_q, a tick happens when it reaches psc_q.
  logic [PRESCALE_W-1:0] div_q, div_nx;

  logic [WIDTH-1:0]      count_nx;
  logic                  done_nx;

  logic                  tick;
  logic                  at_limit;

  assign tick     = (div_q == psc_q);
  assign at_limit = (count == lim_q);

  // busy comes straight from the state register. It therefore drops on the
  // same edge that enters DONE, which is the edge that raises done.
  assign busy = (state == RUN) || (state == HOLD);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      done   <= 1'b0;
      div_q  <= '0;
      lim_q  <= '0;
      psc_q  <= '0;
      auto_q <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      done   <= done_nx;
      div_q  <= div_nx;
      lim_q  <= lim_nx;
      psc_q  <= psc_nx;
      auto_q <= auto_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control. Per-cycle priority is stop > pause > tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    count_nx = count;
    div_nx   = div_q;
    lim_nx   = lim_q;
    psc_nx   = psc_q;
    auto_nx  = auto_q;
    done_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        // start is honoured only without a simultaneous stop.
        if (start && !stop) begin
          lim_nx   = limit;
          psc_nx   = prescale;
          auto_nx  = mode;
          count_nx = '0;
          div_nx   = '0;
          state_nx = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          count_nx = '0;
          div_nx   = '0;
          state_nx = IDLE;
        end else if (pause) begin
          // Nothing advances on the pausing cycle. The prescaler phase is
          // left as it is so the interrupted period resumes where it stopped.
          state_nx = HOLD;
        end else if (tick) begin
          div_nx = '0;
          if (at_limit) begin
            // Terminal event. The comparison against the limit means the
            // count never relies on natural WIDTH-bit overflow.
            done_nx = 1'b1;
            if (auto_q) begin
              count_nx = '0;
            end else begin
              state_nx = DONE;
            end
          end else begin
            count_nx = count + WIDTH'(1);
          end
        end else begin
          div_nx = div_q + PRESCALE_W'(1);
        end
      end

      HOLD: begin
        if (stop) begin
          count_nx = '0;
          div_nx   = '0;
          state_nx = IDLE;
        end else if (!pause) begin
          // The release cycle is also frozen. Counting resumes on the next clock.
          state_nx = RUN;
        end
      end

      DONE: begin
        // Single-cycle state. The final count stays visible in IDLE unless the
        // run is explicitly stopped.
        state_nx = IDLE;
        if (stop) begin
          count_nx = '0;
          div_nx   = '0;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Scoreboard bench for up_counter_ctrl. A stimulus process drives inputs on
// the falling edge. On the rising edge it advances a reference model built
// on elapsed-clock arithmetic and queues the expected outputs. A monitor
// pops the queue on each falling edge and compares against the DUT.
module tb_up_counter_ctrl;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, pause, mode;
  logic [W-1:0]  limit;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          busy, done;

  up_counter_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .limit    (limit),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  // ---------------------------------------------------------------------------
  // Reference model. A run is described by the number of non-frozen clocks k
  // since start. The ticks so far are k/(P+1). A terminal event occurs when
  // the tick count is a multiple of L+1. The displayed count is
  // ticks mod (L+1).
  // ---------------------------------------------------------------------------
  bit       m_run;     // run in progress (busy)
  bit       m_held;    // frozen by pause
  bit       m_fin;     // one-shot just finished, one cycle before idle
  int       m_k;
  int       m_L, m_P;
  bit       m_auto;
  int       m_cnt;
  bit       m_done;

  task automatic model_step();
    int ticks;
    if (rst) begin
      m_run = 0; m_held = 0; m_fin = 0; m_k = 0; m_cnt = 0; m_done = 0;
      m_L = 0; m_P = 0; m_auto = 0;
      return;
    end
    m_done = 0;
    if (m_fin) begin
      m_fin = 0;
      if (stop) m_cnt = 0;
    end else if (!m_run) begin
      if (start && !stop) begin
        m_run = 1; m_held = 0; m_k = 0; m_cnt = 0;
        m_L = int'(limit); m_P = int'(prescale); m_auto = mode;
      end
    end else if (stop) begin
      m_run = 0; m_held = 0; m_cnt = 0;
    end else if (m_held) begin
      if (!pause) m_held = 0;
    end else if (pause) begin
      m_held = 1;
    end else begin
      m_k++;
      if (m_k % (m_P + 1) == 0) begin
        ticks = m_k / (m_P + 1);
        if (ticks % (m_L + 1) == 0) begin
          m_done = 1;
          if (m_auto) m_cnt = 0;
          else begin
            m_cnt = m_L; m_run = 0; m_fin = 1;
          end
        end else begin
          m_cnt = ticks % (m_L + 1);
        end
      end
    end
  endtask

  // One clock: inputs already driven (at a falling edge); model on the rising
  // edge, queue the expectation, return at the next falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    model_step();
    e.count = W'(m_cnt);
    e.busy  = m_run;
    e.done  = m_done;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; pause = 0;
  endtask

  task automatic begin_run(input logic md, input int lim, input int psc);
    start = 1; stop = 0; pause = 0; mode = md;
    limit = W'(lim); prescale = PW'(psc);
    step();
    start = 0;
    // Scramble the parameter inputs. The latched run must not notice.
    limit = W'($urandom); prescale = PW'($urandom); mode = ~md;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        nvec++;
        if (count !== e.count || busy !== e.busy || done !== e.done) begin
          nerr++;
          $display("FAIL vec%0d @%0t: count=%0d busy=%b done=%b, expected count=%0d busy=%b done=%b",
                   nvec, $time, count, busy, done, e.count, e.busy, e.done);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1; mode = 0; limit = '0; prescale = '0;
    idle_inputs();
    @(negedge clk);
    steps(2);
    rst = 0;
    steps(2);

    // One-shot limit 5, prescale 0: counts 1..5, done on the 6th clock, then idle.
    begin_run(1'b0, 5, 0);
    steps(8);

    // Reset mid-run at count 3, applied between edges.
    begin_run(1'b0, 5, 0);
    steps(3);
    #2 rst = 1;
    #1;
    nvec++;
    if (count !== 0 || busy !== 0 || done !== 0) begin
      nerr++;
      $display("FAIL async_reset: count=%0d busy=%b done=%b, expected 0 0 0", count, busy, done);
    end
    @(negedge clk);
    step();
    rst = 0;
    steps(4);             // no start: must stay idle

    // Auto-reload limit 3, then limit 15 (15 -> 0 with done), limit 0 + prescale 1.
    begin_run(1'b1, 3, 0);
    steps(13);
    stop = 1; step(); stop = 0;
    begin_run(1'b1, 15, 0);
    steps(35);
    stop = 1; step(); stop = 0;
    begin_run(1'b1, 0, 1);
    steps(7);
    stop = 1; step(); stop = 0;

    // Prescale 2, limit 2, one-shot: done 9 clocks after start.
    begin_run(1'b0, 2, 2);
    steps(11);

    // Pause for 4 cycles at count 2 with the prescaler mid-phase.
    begin_run(1'b0, 5, 2);
    steps(7);
    pause = 1; steps(4);
    pause = 0; steps(20);

    // Stop at count 4, start+stop in idle, start during a run.
    begin_run(1'b0, 9, 0);
    steps(4);
    stop = 1; step(); stop = 0;
    steps(2);
    start = 1; stop = 1; limit = 4'd3; step();
    start = 0; stop = 0; steps(2);
    begin_run(1'b0, 6, 0);
    steps(2);
    start = 1; limit = 4'd1; mode = 1; steps(2);
    start = 0; steps(8);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      mode     = $urandom_range(0, 1);
      limit    = W'($urandom_range(0, 15));
      prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1; step(); rst = 0;
      end else begin
        step();
      end
    end
    idle_inputs();
    stop = 1; step(); stop = 0;
    steps(2);

    // Drain the scoreboard with a bounded wait.
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
